// File: rtl/regfile_2r1w_pkg.sv
// Shared CPU constants and types for the register file, decoder and control unit.
package regfile_2r1w_pkg;

  localparam int REG_W    = 32;
  localparam int REG_AW   = 5;
  localparam int REG_ZERO = 0;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t R_ZERO = reg_addr_t'(REG_ZERO);
  localparam reg_addr_t R_SP   = reg_addr_t'(29);
  localparam reg_addr_t R_RA   = reg_addr_t'(31);

endpackage

// File: rtl/regfile_2r1w_if.sv
// Read/write/debug port bundle of the register file; the datapath is master.
interface regfile_2r1w_if
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH = REG_W,
  parameter int AW    = REG_AW
) ();

  logic [AW-1:0]    Ra;
  logic [AW-1:0]    Rb;
  logic [WIDTH-1:0] Qa;
  logic [WIDTH-1:0] Qb;
  logic             We;
  logic [AW-1:0]    Wr;
  logic [WIDTH-1:0] D;
  logic [AW-1:0]    Rdbg;
  logic [WIDTH-1:0] Qdbg;

  modport master (
    output Ra, Rb, We, Wr, D, Rdbg,
    input  Qa, Qb, Qdbg
  );

  modport slave (
    input  Ra, Rb, We, Wr, D, Rdbg,
    output Qa, Qb, Qdbg
  );

endinterface

// File: rtl/regfile_2r1w_rdport.sv
// One combinational read port: array mux, r0 forcing, optional write bypass.
module regfile_2r1w_rdport
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH     = REG_W,
  parameter int AW        = REG_AW,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic [WIDTH-1:0] regs [1<<AW],
  input  logic [AW-1:0]    addr,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic             hit;
  logic             is_zero;
  logic [WIDTH-1:0] mux_q;

  // Bypass compare works on addresses only, so it runs alongside the read mux
  // and joins the data path as the final 2:1 select.
  assign hit     = BYPASS_EN && we && !rst && (wr != '0) && (wr == addr);
  assign is_zero = (addr == AW'(REG_ZERO));
  assign mux_q   = regs[addr];

  always_comb begin
    // NOTE: q gets a value on every path before any condition, so no latch is inferred.
    q = mux_q;
    if (is_zero) q = '0;
    if (hit)     q = d;
  end

endmodule

// File: rtl/regfile_2r1w.sv
// 2^AW x WIDTH register file: ports A/B (bypassable), debug port, one write port.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH  = REG_W,
  parameter int AW     = REG_AW,
  parameter bit BYPASS = 1'b1
) (
  input logic            Clk,
  input logic            Rst,
  regfile_2r1w_if.slave  bus
);

  localparam int NREG = 1 << AW;

  logic [WIDTH-1:0] regs [NREG];

  // NOTE: the whole array is cleared on reset, which rules out a RAM macro;
  // the CPU relies on every register reading 0 after reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) begin
        // NOTE: state is always assigned with <= so all flops update from pre-edge values.
        regs[i] <= '0;
      end
    end else if (bus.We && bus.Wr != '0) begin
      regs[bus.Wr] <= bus.D;
    end
  end

  regfile_2r1w_rdport #(.WIDTH(WIDTH), .AW(AW), .BYPASS_EN(BYPASS)) u_port_a (
    .regs (regs),
    .addr (bus.Ra),
    .rst  (Rst),
    .we   (bus.We),
    .wr   (bus.Wr),
    .d    (bus.D),
    .q    (bus.Qa)
  );

  regfile_2r1w_rdport #(.WIDTH(WIDTH), .AW(AW), .BYPASS_EN(BYPASS)) u_port_b (
    .regs (regs),
    .addr (bus.Rb),
    .rst  (Rst),
    .we   (bus.We),
    .wr   (bus.Wr),
    .d    (bus.D),
    .q    (bus.Qb)
  );

  // Debug port shows committed contents only.
  regfile_2r1w_rdport #(.WIDTH(WIDTH), .AW(AW), .BYPASS_EN(1'b0)) u_port_dbg (
    .regs (regs),
    .addr (bus.Rdbg),
    .rst  (Rst),
    .we   (bus.We),
    .wr   (bus.Wr),
    .d    (bus.D),
    .q    (bus.Qdbg)
  );

endmodule
